alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving operand/result width in bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request carries a valid operation.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port src1  input  WIDTH  operand A.
REQ-007 SHALL have port src2  input  WIDTH  operand B.
REQ-008 SHALL have port ainvert  input  1  invert operand A (logic/arith ops only).
REQ-009 SHALL have port binvert  input  1  invert operand B and force carry-in to 1 (logic/arith ops only).
REQ-010 SHALL have port op  input  3  000 AND, 001 OR, 010 ADD, 011 SLT, 100 MUL (unsigned); 101-111 reserved.
REQ-011 SHALL have port out_valid  output  1  result registers hold a completed operation.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port result  output  WIDTH  low result word.
REQ-014 SHALL have port result_hi  output  WIDTH  high product word (MUL only, else 0).
REQ-015 SHALL have port zero  output  1  result == 0 (low word only).
REQ-016 SHALL have port overflow  output  1  signed add overflow, or MUL high word nonzero.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, DONE; in_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge with in_valid & in_ready, capturing src1, src2, ainvert, binvert, op in that same edge.
REQ-019 For ops 000-011 SHALL compute from a' = ainvert ? ~src1 : src1 and b' = binvert ? ~src2 : src2, carry-in = binvert, transition IDLE->DONE, and assert out_valid 1 cycle after acceptance.
REQ-020 AND/OR SHALL give a'&b' / a'|b'; ADD SHALL give (a'+b'+cin) mod 2^WIDTH.
REQ-021 For ADD and SLT, overflow SHALL equal carry into MSB XOR carry out of MSB of the adder; for AND/OR, overflow = 0.
REQ-022 SLT SHALL give result = {WIDTH-1 zeros, sum[WIDTH-1] XOR overflow}, with overflow reported as for ADD.
REQ-023 MUL SHALL ignore ainvert/binvert, go IDLE->EXEC, run one shift-add step per cycle for exactly WIDTH cycles, then go EXEC->DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-024 MUL SHALL give {result_hi, result} = src1 * src2 (unsigned, 2*WIDTH bits) and overflow = (result_hi != 0).
REQ-025 Reserved ops SHALL complete in 1 cycle like REQ-019, with result = 0, result_hi = 0, overflow = 0, zero = 1.
REQ-026 result_hi SHALL be 0 for every non-MUL op.
REQ-027 In DONE, out_valid = 1 and result, result_hi, zero, overflow SHALL remain stable until out_valid & out_ready, then DONE->IDLE.
REQ-028 Outputs SHALL not change in IDLE or EXEC; they keep the last delivered values, and out_valid = 0.
REQ-029 in_valid in EXEC or DONE SHALL be ignored; no request is lost only if the source holds it until in_ready.
REQ-030 Peak throughput SHALL be one operation per 2 cycles for ops 000-011, with no result reordering.
REQ-031 Counter in EXEC SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap before EXEC exits.

Reset
REQ-032 rst asserted SHALL asynchronously force state IDLE, and set out_valid = 0, result = 0, result_hi = 0, zero = 1, overflow = 0, and the EXEC counter to 0.
REQ-033 rst asserted during EXEC or DONE SHALL abort the operation with no out_valid pulse; in_ready = 1 the first cycle after rst deasserts.

Verification (WIDTH = 16)
REQ-034 ADD, src1 = 0x7FFF, src2 = 0x0001, ainvert = binvert = 0 -> one cycle later out_valid = 1, result = 0x8000, overflow = 1, zero = 0.
REQ-035 SLT, src1 = 0x8000, src2 = 0x0001, binvert = 1 -> result = 0x0001, overflow = 1; the same op with src1 = src2 = 0x0005 -> result = 0x0000, zero = 1.
REQ-036 MUL, src1 = 0xFFFF, src2 = 0x0002 -> out_valid exactly 17 cycles after acceptance, result_hi = 0x0001, result = 0xFFFE, overflow = 1; in_ready = 0 throughout.
REQ-037 Hold out_ready = 0 for 5 cycles after DONE -> outputs stable, in_ready = 0, and new in_valid is ignored; out_ready = 1 -> IDLE next cycle.
REQ-038 NOR via AND with ainvert = binvert = 1, src1 = 0x00F0, src2 = 0x0F00 -> result = 0xF00F.
REQ-039 Assert rst at MUL cycle 8 -> out_valid stays 0, all outputs at reset values, and in_ready = 1 after release.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a single-cycle logic/arithmetic path (AND, OR,
// ADD, SLT) and a multi-cycle unsigned shift-add multiplier. Requests and
// results use valid/ready handshakes. A small IDLE/EXEC/DONE FSM holds each
// result in registers until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  // The counter must be able to hold WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt_p0;
  logic [WIDTH-1:0]   mcand_p0;
  logic [2*WIDTH-1:0] prod_p0;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     alu_out;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               accept;
  logic               last_step;

  // Single-cycle ALU. Returns {overflow, result}. Overflow for ADD/SLT is the
  // carry into the MSB XOR the carry out of the MSB. Reserved ops yield zeros.
  function automatic logic [WIDTH:0] alu_calc(
    input logic [2:0]       f,
    input logic [WIDTH-1:0] a_in,
    input logic [WIDTH-1:0] b_in,
    input logic             ai,
    input logic             bi
  );
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic             c_msb;
    logic             ovf;
    logic             ovf_o;
    a     = ai ? ~a_in : a_in;
    b     = bi ? ~b_in : b_in;
    sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, bi};
    c_msb = sum[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
    ovf   = c_msb ^ sum[WIDTH];
    res   = '0;
    ovf_o = 1'b0;
    case (f)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        ovf_o = ovf;
      end
      OP_SLT: begin
        res   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
        ovf_o = ovf;
      end
      default: begin
        res   = '0;
        ovf_o = 1'b0;
      end
    endcase
    return {ovf_o, res};
  endfunction

  // One shift-add step. The product register holds {partial_hi, multiplier};
  // the multiplier LSB selects whether the multiplicand is added to the upper
  // half, then everything shifts right by one with the adder carry entering
  // from the top.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [2*WIDTH-1:0] prod,
    input logic [WIDTH-1:0]   mcand
  );
    logic [WIDTH:0] acc;
    acc = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {acc, prod[WIDTH-1:1]};
  endfunction

  assign alu_out   = alu_calc(op, src1, src2, ainvert, binvert);
  assign alu_res   = alu_out[WIDTH-1:0];
  assign alu_ovf   = alu_out[WIDTH];
  assign prod_nxt  = mul_step(prod_p0, mcand_p0);
  assign accept    = in_valid && (state == IDLE);
  assign last_step = (state == EXEC) && (cnt_p0 == CNT_W'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Next-state logic: MUL goes through EXEC, everything else straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (op == OP_MUL) ? EXEC : DONE;
      EXEC: if (last_step) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Multiply step counter: cleared on acceptance, one count per EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_p0 <= '0;
    else if (accept)        cnt_p0 <= '0;
    else if (state == EXEC) cnt_p0 <= cnt_p0 + 1'b1;
  end

  // Multiplier operands: load on acceptance, shift-add each EXEC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_p0 <= src1;
      prod_p0  <= {{WIDTH{1'b0}}, src2};
    end else if (state == EXEC) begin
      prod_p0 <= prod_nxt;
    end
  end

  // Result registers: written only when an operation completes, so they hold
  // the last delivered result through IDLE and EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
    end else if (accept && (op != OP_MUL)) begin
      result    <= alu_res;
      result_hi <= '0;
      zero      <= (alu_res == '0);
      overflow  <= alu_ovf;
    end else if (last_step) begin
      result    <= prod_nxt[WIDTH-1:0];
      result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
      zero      <= (prod_nxt[WIDTH-1:0] == '0);
      overflow  <= |prod_nxt[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomised bench for alu_seq (WIDTH = 16) with a queue-based
// scoreboard fed by an independent reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         ainvert;
  logic         binvert;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         overflow;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .ainvert   (ainvert),
    .binvert   (binvert),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: signed overflow from operand/result signs, MUL by '*'.
  function automatic exp_t model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ai, input logic bi);
    exp_t         e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] s;
    logic [2*W-1:0] p;
    logic         sov;
    x = ai ? ~a : a;
    y = bi ? ~b : b;
    s = x + y + W'(bi);
    sov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    p = '0;
    e.res = '0;
    e.hi  = '0;
    e.ovf = 1'b0;
    e.lat = 1;
    case (f)
      3'd0: e.res = x & y;
      3'd1: e.res = x | y;
      3'd2: begin e.res = s; e.ovf = sov; end
      3'd3: begin e.res = {{(W-1){1'b0}}, s[W-1] ^ sov}; e.ovf = sov; end
      3'd4: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.ovf = (e.hi != '0);
        e.lat = W + 1;
      end
      default: e.res = '0;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic start_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ai, input logic bi);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    op = f; src1 = a; src2 = b; ainvert = ai; binvert = bi;
    in_valid = 1'b1;
    sb.push_back(model(f, a, b, ai, bi));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int   lat;
    logic busy_ok;
    exp_t e;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check({tag, "/out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "/latency"}, 64'(lat), 64'(e.lat));
    if (e.lat > 1) check({tag, "/busy_in_ready"}, 64'(busy_ok), 64'd1);
    check({tag, "/result"}, 64'(result), 64'(e.res));
    check({tag, "/result_hi"}, 64'(result_hi), 64'(e.hi));
    check({tag, "/zero"}, 64'(zero), 64'(e.zero));
    check({tag, "/overflow"}, 64'(overflow), 64'(e.ovf));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/idle_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "/idle_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic         seen;
    logic [W-1:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; ainvert = 1'b0; binvert = 1'b0; op = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst/in_ready", 64'(in_ready), 64'd1);
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/result", 64'(result), 64'd0);
    check("rst/result_hi", 64'(result_hi), 64'd0);
    check("rst/zero", 64'(zero), 64'd1);
    check("rst/overflow", 64'(overflow), 64'd0);

    // Signed add overflow
    start_op(3'd2, 16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_out("add_ovf"); take("add_ovf");
    // SLT, overflowing compare and equal operands
    start_op(3'd3, 16'h8000, 16'h0001, 1'b0, 1'b1); wait_out("slt_ovf"); take("slt_ovf");
    start_op(3'd3, 16'h0005, 16'h0005, 1'b0, 1'b1); wait_out("slt_eq"); take("slt_eq");
    // NOR via AND with both inversions
    start_op(3'd0, 16'h00F0, 16'h0F00, 1'b1, 1'b1); wait_out("nor"); take("nor");
    start_op(3'd1, 16'h1200, 16'h0034, 1'b0, 1'b0); wait_out("or"); take("or");
    start_op(3'd2, 16'h0005, 16'h0007, 1'b0, 1'b1); wait_out("sub_neg"); take("sub_neg");
    start_op(3'd2, 16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_out("add_wrap"); take("add_wrap");
    // Reserved ops
    start_op(3'd5, 16'h1234, 16'h5678, 1'b1, 1'b0); wait_out("rsv5"); take("rsv5");
    start_op(3'd7, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1); wait_out("rsv7"); take("rsv7");
    // Multiplies
    start_op(3'd4, 16'hFFFF, 16'h0002, 1'b0, 1'b0); wait_out("mul_ovf"); take("mul_ovf");
    start_op(3'd4, 16'h1234, 16'h0056, 1'b0, 1'b0); wait_out("mul_small"); take("mul_small");
    start_op(3'd4, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1); wait_out("mul_max"); take("mul_max");
    start_op(3'd4, 16'h0000, 16'hABCD, 1'b0, 1'b0); wait_out("mul_zero"); take("mul_zero");

    // Consumer stalls in DONE while a new request is offered
    start_op(3'd2, 16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_out("hold");
    op = 3'd0; src1 = 16'hFFFF; src2 = 16'h0F0F; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold/out_valid", 64'(out_valid), 64'd1);
      check("hold/in_ready", 64'(in_ready), 64'd0);
      check("hold/result", 64'(result), 64'h2345);
      check("hold/zero", 64'(zero), 64'd0);
    end
    in_valid = 1'b0;
    take("hold");
    held = result;
    @(posedge clk); #1;
    check("idle_hold/result", 64'(result), 64'(held));
    check("idle_hold/value", 64'(result), 64'h2345);

    // Reset in the middle of a multiply
    start_op(3'd4, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    void'(sb.pop_front());
    check("mid_rst/out_valid", 64'(out_valid), 64'd0);
    check("mid_rst/result", 64'(result), 64'd0);
    check("mid_rst/result_hi", 64'(result_hi), 64'd0);
    check("mid_rst/zero", 64'(zero), 64'd1);
    check("mid_rst/overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst/in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("mid_rst/no_pulse", 64'(seen), 64'd0);
    start_op(3'd2, 16'h0100, 16'h0023, 1'b0, 1'b0); wait_out("post_rst"); take("post_rst");

    // Randomised mix of all ops
    for (int i = 0; i < 24; i++) begin
      start_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_out("rnd");
      take("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
